// File: rtl/emirror_pkg.sv
`default_nettype none
// ============================================================================
// Module   : emirror_pkg
// Brief    : Shared DVP byte-FSM encoding and RGB565 field layout.
// Revision : 1.0
// ============================================================================
package emirror_pkg;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_ARM  = 3'd1,
        ST_IDLE = 3'd2,
        ST_HI   = 3'd3,
        ST_LO   = 3'd4
    } dvp_state_e;

    localparam int C_PIX_W = 16;
    localparam int C_R_MSB = 15;
    localparam int C_R_LSB = 11;
    localparam int C_G_MSB = 10;
    localparam int C_G_LSB = 5;
    localparam int C_B_MSB = 4;
    localparam int C_B_LSB = 0;

    // Green straddles the byte boundary: three bits from each byte.
    function automatic logic [C_PIX_W-1:0] pack_rgb565(input logic [7:0] hi,
                                                       input logic [7:0] lo);
        logic [C_PIX_W-1:0] p;
        p                  = '0;
        p[C_R_MSB:C_R_LSB] = hi[7:3];
        p[C_G_MSB:C_G_LSB] = {hi[2:0], lo[7:5]};
        p[C_B_MSB:C_B_LSB] = lo[4:0];
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_line_stats.sv
`default_nettype none
// ============================================================================
// Module   : dvp_line_stats
// Brief    : Per-line pixel count, per-frame line count and line-length check.
// Revision : 1.0
// ============================================================================
module dvp_line_stats
    import emirror_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             PIXCLK,
    input  logic             reset,
    input  logic             pix_inc_i,
    input  logic             eol_i,
    input  logic             frame_start_i,
    input  logic             frame_end_i,
    output logic [CNT_W-1:0] line_px_o,
    output logic [CNT_W-1:0] frame_lines_o,
    output logic             len_err_o
);

    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] ref_len_q, ref_len_d;
    logic [CNT_W-1:0] line_px_q, line_px_d;
    logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
    logic             first_line_q, first_line_d;
    logic             frame_bad_q, frame_bad_d;
    logic             len_err_q, len_err_d;

    logic [CNT_W-1:0] w_line_cnt_inc;
    logic             w_mismatch;
    logic             w_frame_bad;

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (eol_i) begin
            pix_cnt_d = '0;
        end else if (pix_inc_i && (pix_cnt_q != '1)) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        w_line_cnt_inc = line_cnt_q;
        if (eol_i && (line_cnt_q != '1)) begin
            w_line_cnt_inc = line_cnt_q + 1'b1;
        end

        w_mismatch  = eol_i && !first_line_q && (pix_cnt_q != ref_len_q);
        w_frame_bad = frame_bad_q | w_mismatch;

        line_px_d     = eol_i ? pix_cnt_q : line_px_q;
        ref_len_d     = (eol_i && first_line_q) ? pix_cnt_q : ref_len_q;
        frame_lines_d = frame_end_i ? w_line_cnt_inc : frame_lines_q;

        // A line cut short by vsync is counted into the frame that just ended.
        line_cnt_d   = frame_start_i ? '0 : w_line_cnt_inc;
        first_line_d = frame_start_i ? 1'b1 : (eol_i ? 1'b0 : first_line_q);
        frame_bad_d  = frame_start_i ? 1'b0 : w_frame_bad;

        len_err_d = len_err_q;
        if (w_mismatch) begin
            len_err_d = 1'b1;
        end else if (frame_end_i && !w_frame_bad) begin
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge PIXCLK or posedge reset) begin
        if (reset) begin
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            ref_len_q     <= '0;
            line_px_q     <= '0;
            frame_lines_q <= '0;
            first_line_q  <= 1'b0;
            frame_bad_q   <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            ref_len_q     <= ref_len_d;
            line_px_q     <= line_px_d;
            frame_lines_q <= frame_lines_d;
            first_line_q  <= first_line_d;
            frame_bad_q   <= frame_bad_d;
            len_err_q     <= len_err_d;
        end
    end

    assign line_px_o     = line_px_q;
    assign frame_lines_o = frame_lines_q;
    assign len_err_o     = len_err_q;

endmodule
`default_nettype wire

// File: rtl/dvp_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : dvp_pixel_packer
// Brief    : DVP byte-pair to RGB565 packer with frame lock and line stats.
// Revision : 1.0
// ============================================================================
module dvp_pixel_packer
    import emirror_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 12
) (
    input  logic              PIXCLK,
    input  logic              reset,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [15:0]       pix_o,
    output logic              pix_valid_o,
    output logic              sof_o,
    output logic              sol_o,
    output logic [CNT_W-1:0]  line_px_o,
    output logic [CNT_W-1:0]  frame_lines_o,
    output logic              odd_byte_o,
    output logic              len_err_o,
    output logic              locked_o
);

    dvp_state_e  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_q, pix_d;
    logic        pix_valid_q, pix_valid_d;
    logic        sof_q, sof_d;
    logic        sol_q, sol_d;
    logic        odd_q, odd_d;
    logic        locked_q, locked_d;
    logic        sof_arm_q, sof_arm_d;
    logic        sol_arm_q, sol_arm_d;
    logic        vsync_prev_q, vsync_prev_d;

    logic [7:0]  w_byte;
    logic        w_vs_rise;
    logic        w_eol;
    logic        w_frame_start;
    logic        w_frame_end;
    logic        w_unused_lsb;

    assign w_byte       = data_i[DATA_W-1 -: 8];
    assign w_unused_lsb = ^data_i;
    assign w_vs_rise    = vsync_i & ~vsync_prev_q;

    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        pix_d         = pix_q;
        pix_valid_d   = 1'b0;
        sof_d         = 1'b0;
        sol_d         = 1'b0;
        odd_d         = 1'b0;
        sof_arm_d     = sof_arm_q;
        sol_arm_d     = sol_arm_q;
        vsync_prev_d  = vsync_i;
        w_eol         = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;

        if (state_q == ST_SYNC) begin
            if (vsync_i) begin
                state_d = ST_ARM;
            end
        end else if (state_q == ST_ARM) begin
            if (!vsync_i) begin
                state_d       = ST_IDLE;
                sof_arm_d     = 1'b1;
                w_frame_start = 1'b1;
            end
        end else if (w_vs_rise) begin
            // Vsync wins over href: any byte on the bus now is left unpaired.
            w_eol         = (state_q != ST_IDLE) | href_i;
            odd_d         = (state_q == ST_LO) | href_i;
            w_frame_end   = 1'b1;
            w_frame_start = 1'b1;
            sof_arm_d     = 1'b1;
            sol_arm_d     = 1'b0;
            state_d       = ST_IDLE;
        end else if (vsync_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (href_i) begin
                        hi_d      = w_byte;
                        sol_arm_d = 1'b1;
                        state_d   = ST_LO;
                    end
                end
                ST_LO: begin
                    if (href_i) begin
                        pix_d       = pack_rgb565(hi_q, w_byte);
                        pix_valid_d = 1'b1;
                        sof_d       = sof_arm_q;
                        sol_d       = sol_arm_q;
                        sof_arm_d   = 1'b0;
                        sol_arm_d   = 1'b0;
                        state_d     = ST_HI;
                    end else begin
                        odd_d   = 1'b1;
                        w_eol   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_HI: begin
                    if (href_i) begin
                        hi_d    = w_byte;
                        state_d = ST_LO;
                    end else begin
                        w_eol   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end

        locked_d = (state_d == ST_IDLE) || (state_d == ST_HI) || (state_d == ST_LO);
    end

    always_ff @(posedge PIXCLK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            hi_q         <= '0;
            pix_q        <= '0;
            pix_valid_q  <= 1'b0;
            sof_q        <= 1'b0;
            sol_q        <= 1'b0;
            odd_q        <= 1'b0;
            locked_q     <= 1'b0;
            sof_arm_q    <= 1'b0;
            sol_arm_q    <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            pix_q        <= pix_d;
            pix_valid_q  <= pix_valid_d;
            sof_q        <= sof_d;
            sol_q        <= sol_d;
            odd_q        <= odd_d;
            locked_q     <= locked_d;
            sof_arm_q    <= sof_arm_d;
            sol_arm_q    <= sol_arm_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    dvp_line_stats #(
        .CNT_W (CNT_W)
    ) u_line_stats (
        .PIXCLK        (PIXCLK),
        .reset         (reset),
        .pix_inc_i     (pix_valid_d),
        .eol_i         (w_eol),
        .frame_start_i (w_frame_start),
        .frame_end_i   (w_frame_end),
        .line_px_o     (line_px_o),
        .frame_lines_o (frame_lines_o),
        .len_err_o     (len_err_o)
    );

    assign pix_o       = pix_q;
    assign pix_valid_o = pix_valid_q;
    assign sof_o       = sof_q;
    assign sol_o       = sol_q;
    assign odd_byte_o  = odd_q;
    assign locked_o    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvp_pixel_packer
// Brief    : Directed self-checking bench for dvp_pixel_packer.
// Revision : 1.0
// ============================================================================
module tb_dvp_pixel_packer;

    logic        PIXCLK  = 1'b0;
    logic        reset   = 1'b1;
    logic        vsync_i = 1'b0;
    logic        href_i  = 1'b0;
    logic [9:0]  data_i  = '0;
    logic [15:0] pix_o;
    logic        pix_valid_o, sof_o, sol_o, odd_byte_o, len_err_o, locked_o;
    logic [11:0] line_px_o, frame_lines_o;

    int checks = 0;
    int errors = 0;
    int n_pix = 0, n_sof = 0, n_sol = 0, n_odd = 0, n_badpix = 0;
    logic [15:0] exp_pix = 16'hFF00;

    always #5 PIXCLK = ~PIXCLK;

    dvp_pixel_packer #(.DATA_W(10), .CNT_W(12)) dut (
        .PIXCLK        (PIXCLK),
        .reset         (reset),
        .vsync_i       (vsync_i),
        .href_i        (href_i),
        .data_i        (data_i),
        .pix_o         (pix_o),
        .pix_valid_o   (pix_valid_o),
        .sof_o         (sof_o),
        .sol_o         (sol_o),
        .line_px_o     (line_px_o),
        .frame_lines_o (frame_lines_o),
        .odd_byte_o    (odd_byte_o),
        .len_err_o     (len_err_o),
        .locked_o      (locked_o)
    );

    always @(negedge PIXCLK) begin
        if (pix_valid_o) begin
            n_pix++;
            if (pix_o !== exp_pix) n_badpix++;
        end
        if (sof_o) n_sof++;
        if (sol_o) n_sol++;
        if (odd_byte_o) n_odd++;
    end

    task automatic drive(input logic v, input logic h, input logic [9:0] d);
        vsync_i = v; href_i = h; data_i = d;
        @(posedge PIXCLK); #1;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 1'b0, 10'h000);
    endtask

    task automatic send_line(input int nbytes, input logic [9:0] d_hi, input logic [9:0] d_lo);
        for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? d_hi : d_lo);
        drive(1'b0, 1'b0, 10'h000);
    endtask

    task automatic vs_pulse();
        repeat (3) drive(1'b1, 1'b0, 10'h000);
        repeat (2) drive(1'b0, 1'b0, 10'h000);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 10'h000);
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (pix_o !== 16'h0) begin errors++; $display("FAIL reset_pix: got %h expected 0000", pix_o); end
        checks++; if (pix_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid_o); end
        checks++; if ({sof_o, sol_o, odd_byte_o, len_err_o} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {sof_o, sol_o, odd_byte_o, len_err_o}); end
        checks++; if (line_px_o !== 12'd0) begin errors++; $display("FAIL reset_line_px: got %0d expected 0", line_px_o); end
        checks++; if (frame_lines_o !== 12'd0) begin errors++; $display("FAIL reset_frame_lines: got %0d expected 0", frame_lines_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked_o); end
        vsync_i = 1'b0;
        reset = 1'b0;
        gap(2);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL unlocked_after_reset: got %b expected 0", locked_o); end
    endtask

    task automatic test_two_frames();
        int p0, s0, l0, o0, b0;
        exp_pix = 16'hFF00;
        p0 = n_pix; o0 = n_odd;
        for (int i = 0; i < 4; i++) begin send_line(8, 10'h3FC, 10'h000); gap(2); end
        checks++; if (n_pix - p0 !== 0) begin errors++; $display("FAIL frame1_pixels: got %0d expected 0", n_pix - p0); end
        checks++; if (n_odd - o0 !== 0) begin errors++; $display("FAIL frame1_odd: got %0d expected 0", n_odd - o0); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL frame1_locked: got %b expected 0", locked_o); end
        vs_pulse();
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_after_vsync: got %b expected 1", locked_o); end
        p0 = n_pix; s0 = n_sof; l0 = n_sol; b0 = n_badpix;
        drive(1'b0, 1'b1, 10'h3FC);
        checks++; if (pix_valid_o !== 1'b0) begin errors++; $display("FAIL latency_hi_byte: got %b expected 0", pix_valid_o); end
        drive(1'b0, 1'b1, 10'h000);
        checks++; if (pix_valid_o !== 1'b1) begin errors++; $display("FAIL latency_lo_byte: got %b expected 1", pix_valid_o); end
        checks++; if (pix_o !== 16'hFF00) begin errors++; $display("FAIL first_pix: got %h expected ff00", pix_o); end
        checks++; if ({sof_o, sol_o} !== 2'b11) begin errors++; $display("FAIL first_sof_sol: got %b expected 11", {sof_o, sol_o}); end
        for (int i = 2; i < 8; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 10'h3FC : 10'h000);
        drive(1'b0, 1'b0, 10'h000);
        checks++; if (line_px_o !== 12'd4) begin errors++; $display("FAIL frame2_line_px: got %0d expected 4", line_px_o); end
        gap(2);
        for (int i = 0; i < 3; i++) begin send_line(8, 10'h3FC, 10'h000); gap(2); end
        checks++; if (n_pix - p0 !== 16) begin errors++; $display("FAIL frame2_pixels: got %0d expected 16", n_pix - p0); end
        checks++; if (n_sof - s0 !== 1) begin errors++; $display("FAIL frame2_sof: got %0d expected 1", n_sof - s0); end
        checks++; if (n_sol - l0 !== 4) begin errors++; $display("FAIL frame2_sol: got %0d expected 4", n_sol - l0); end
        checks++; if (n_badpix - b0 !== 0) begin errors++; $display("FAIL frame2_pix_data: got %0d bad expected 0", n_badpix - b0); end
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (frame_lines_o !== 12'd4) begin errors++; $display("FAIL frame2_lines: got %0d expected 4", frame_lines_o); end
        checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL frame2_len_err: got %b expected 0", len_err_o); end
        repeat (2) drive(1'b1, 1'b0, 10'h000);
        gap(2);
    endtask

    task automatic test_odd_line();
        int p0, o0, b0;
        exp_pix = 16'hAA55;
        p0 = n_pix; o0 = n_odd; b0 = n_badpix;
        send_line(9, 10'h2A8, 10'h154);
        checks++; if (odd_byte_o !== 1'b1) begin errors++; $display("FAIL odd_pulse: got %b expected 1", odd_byte_o); end
        checks++; if (line_px_o !== 12'd4) begin errors++; $display("FAIL odd_line_px: got %0d expected 4", line_px_o); end
        checks++; if (n_pix - p0 !== 4) begin errors++; $display("FAIL odd_pixels: got %0d expected 4", n_pix - p0); end
        gap(1);
        checks++; if (odd_byte_o !== 1'b0) begin errors++; $display("FAIL odd_one_cycle: got %b expected 0", odd_byte_o); end
        checks++; if (n_odd - o0 !== 1) begin errors++; $display("FAIL odd_count: got %0d expected 1", n_odd - o0); end
        checks++; if (n_badpix - b0 !== 0) begin errors++; $display("FAIL odd_pix_data: got %0d bad expected 0", n_badpix - b0); end
        gap(1);
    endtask

    task automatic test_len_err();
        exp_pix = 16'hFF00;
        vs_pulse();
        send_line(8, 10'h3FC, 10'h000); gap(2);
        send_line(8, 10'h3FC, 10'h000); gap(2);
        checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL len_err_early: got %b expected 0", len_err_o); end
        send_line(6, 10'h3FC, 10'h000);
        checks++; if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_err_set: got %b expected 1", len_err_o); end
        checks++; if (line_px_o !== 12'd3) begin errors++; $display("FAIL short_line_px: got %0d expected 3", line_px_o); end
        gap(2);
        send_line(8, 10'h3FC, 10'h000); gap(2);
        checks++; if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_err_held: got %b expected 1", len_err_o); end
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_err_bad_frame_vs: got %b expected 1", len_err_o); end
        checks++; if (frame_lines_o !== 12'd4) begin errors++; $display("FAIL bad_frame_lines: got %0d expected 4", frame_lines_o); end
        repeat (2) drive(1'b1, 1'b0, 10'h000);
        gap(2);
        send_line(8, 10'h3FC, 10'h000); gap(2);
        send_line(8, 10'h3FC, 10'h000); gap(2);
        checks++; if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_err_until_vs: got %b expected 1", len_err_o); end
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL len_err_clear: got %b expected 0", len_err_o); end
        checks++; if (frame_lines_o !== 12'd2) begin errors++; $display("FAIL clean_frame_lines: got %0d expected 2", frame_lines_o); end
        repeat (2) drive(1'b1, 1'b0, 10'h000);
        gap(2);
    endtask

    task automatic test_counters();
        exp_pix = 16'hFF00;
        for (int i = 0; i < 480; i++) begin
            drive(1'b0, 1'b1, 10'h3FC);
            drive(1'b0, 1'b1, 10'h000);
            gap(2);
        end
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (frame_lines_o !== 12'd480) begin errors++; $display("FAIL frame_lines_480: got %0d expected 480", frame_lines_o); end
        checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL frame_480_len_err: got %b expected 0", len_err_o); end
        repeat (2) drive(1'b1, 1'b0, 10'h000);
        gap(2);
        send_line(10000, 10'h3FC, 10'h000);
        checks++; if (line_px_o !== 12'd4095) begin errors++; $display("FAIL line_px_saturate: got %0d expected 4095", line_px_o); end
        gap(2);
    endtask

    task automatic test_vsync_mid_line();
        int o0;
        vs_pulse();
        exp_pix = 16'hAA55;
        o0 = n_odd;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 10'h2A8 : 10'h154);
        drive(1'b1, 1'b1, 10'h2A8);
        checks++; if (odd_byte_o !== 1'b1) begin errors++; $display("FAIL vs_mid_odd: got %b expected 1", odd_byte_o); end
        checks++; if (line_px_o !== 12'd2) begin errors++; $display("FAIL vs_mid_line_px: got %0d expected 2", line_px_o); end
        checks++; if (frame_lines_o !== 12'd1) begin errors++; $display("FAIL vs_mid_frame_lines: got %0d expected 1", frame_lines_o); end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL vs_mid_locked: got %b expected 1", locked_o); end
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (n_odd - o0 !== 1) begin errors++; $display("FAIL vs_mid_odd_count: got %0d expected 1", n_odd - o0); end
        drive(1'b1, 1'b0, 10'h000);
        gap(2);
        exp_pix = 16'h55AA;
        drive(1'b0, 1'b1, 10'h154);
        checks++; if (pix_valid_o !== 1'b0) begin errors++; $display("FAIL next_frame_hi: got %b expected 0", pix_valid_o); end
        drive(1'b0, 1'b1, 10'h2A8);
        checks++; if (pix_valid_o !== 1'b1 || pix_o !== 16'h55AA) begin errors++; $display("FAIL next_frame_pix: got %b/%h expected 1/55aa", pix_valid_o, pix_o); end
        checks++; if ({sof_o, sol_o} !== 2'b11) begin errors++; $display("FAIL next_frame_sof_sol: got %b expected 11", {sof_o, sol_o}); end
        gap(3);
    endtask

    task automatic test_reset_mid_line();
        int p0, o0;
        exp_pix = 16'hFF00;
        drive(1'b0, 1'b1, 10'h3FC);
        drive(1'b0, 1'b1, 10'h000);
        drive(1'b0, 1'b1, 10'h3FC);
        #3 reset = 1'b1;
        #1;
        checks++; if (pix_o !== 16'h0 || pix_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_pix: got %h/%b expected 0000/0", pix_o, pix_valid_o); end
        checks++; if (line_px_o !== 12'd0 || frame_lines_o !== 12'd0) begin errors++; $display("FAIL midreset_counts: got %0d/%0d expected 0/0", line_px_o, frame_lines_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL midreset_locked: got %b expected 0", locked_o); end
        p0 = n_pix; o0 = n_odd;
        drive(1'b0, 1'b1, 10'h000);
        checks++; if ({pix_valid_o, odd_byte_o, len_err_o, locked_o} !== 4'b0) begin errors++; $display("FAIL midreset_held: got %b expected 0000", {pix_valid_o, odd_byte_o, len_err_o, locked_o}); end
        reset = 1'b0;
        drive(1'b0, 1'b1, 10'h3FC);
        drive(1'b0, 1'b1, 10'h000);
        drive(1'b0, 1'b1, 10'h3FC);
        gap(3);
        checks++; if (n_pix - p0 !== 0 || n_odd - o0 !== 0) begin errors++; $display("FAIL midreset_no_output: got %0d pix %0d odd expected 0 0", n_pix - p0, n_odd - o0); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL midreset_relock_early: got %b expected 0", locked_o); end
        drive(1'b1, 1'b0, 10'h000);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL midreset_arm_locked: got %b expected 0", locked_o); end
        drive(1'b0, 1'b0, 10'h000);
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL midreset_relock: got %b expected 1", locked_o); end
        gap(2);
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_odd_line();
        test_len_err();
        test_counters();
        test_vsync_mid_line();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
